// File: rtl/fir_coef_loader.sv
// Streams FIR coefficient words into a Wishbone coefficient RAM, then optionally reads
// every tap back and compares it against a local shadow copy of what was written.
module fir_coef_loader #(
  parameter int         NUM_TAPS = 33,
  parameter logic [7:0] BASE_ADR = 8'h00,
  parameter int         TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        verify_en,
  input  logic [15:0] s_coef_tdata,
  input  logic        s_coef_tvalid,
  output logic        s_coef_tready,
  output logic [7:0]  wb_adr,
  output logic [15:0] wb_wr_dat,
  input  logic [15:0] wb_rd_dat,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic [1:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [5:0]  err_index
);

  localparam logic [5:0] LAST_IDX      = 6'(NUM_TAPS - 1);
  localparam logic [7:0] TO_LAST       = 8'(TIMEOUT - 1);
  localparam logic [1:0] CODE_MISMATCH = 2'b01;
  localparam logic [1:0] CODE_WB_ERR   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_READ,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic        r_verify;
  logic [7:0]  r_tcnt;
  logic [15:0] r_shadow [64];

  logic        r_tready;
  logic [7:0]  r_adr;
  logic [15:0] r_wr_dat;
  logic        r_we;
  logic        r_stb;
  logic        r_cyc;
  logic [1:0]  r_sel;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [5:0]  r_err_index;

  logic        w_accept;
  logic        w_match;
  logic        w_fail;
  logic [1:0]  w_fail_code;

  function automatic logic [7:0] tap_adr(input logic [5:0] idx);
    return BASE_ADR + {2'b00, idx};
  endfunction

  assign w_accept = (r_state == S_LOAD) && s_coef_tvalid;
  assign w_match  = (wb_rd_dat == r_shadow[r_idx]);

  // Read-phase failure decode; a bus error outranks an acknowledge in the same cycle.
  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
    if (wb_err) begin
      w_fail      = 1'b1;
      w_fail_code = CODE_WB_ERR;
    end else if (wb_ack && !w_match) begin
      w_fail      = 1'b1;
      w_fail_code = CODE_MISMATCH;
    end else if (!wb_ack && (r_tcnt == TO_LAST)) begin
      w_fail      = 1'b1;
      w_fail_code = CODE_TIMEOUT;
    end
  end

  // Shadow copy is pure data: no reset, contents are rewritten on every load.
  always_ff @(posedge clk) begin
    if (w_accept) r_shadow[r_idx] <= s_coef_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_verify    <= 1'b0;
      r_tcnt      <= '0;
      r_tready    <= 1'b0;
      r_adr       <= '0;
      r_wr_dat    <= '0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc       <= 1'b0;
      r_sel       <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'b00;
      r_err_index <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_verify    <= verify_en;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_index <= '0;
            r_busy      <= 1'b1;
            r_tready    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (s_coef_tvalid) begin
            r_state  <= S_WRITE;
            r_tready <= 1'b0;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_we     <= 1'b1;
            r_sel    <= 2'b11;
            r_adr    <= tap_adr(r_idx);
            r_wr_dat <= s_coef_tdata;
          end
        end
        S_WRITE: begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_we  <= 1'b0;
          r_sel <= 2'b00;
          if (r_idx != LAST_IDX) begin
            r_idx    <= r_idx + 6'd1;
            r_tready <= 1'b1;
            r_state  <= S_LOAD;
          end else if (r_verify) begin
            r_idx   <= '0;
            r_tcnt  <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_sel   <= 2'b11;
            r_adr   <= tap_adr(6'd0);
            r_state <= S_READ;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          r_tcnt <= r_tcnt + 8'd1;
          if (w_fail) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_sel       <= 2'b00;
            r_adr       <= '0;
            r_error     <= 1'b1;
            r_err_code  <= w_fail_code;
            r_err_index <= r_idx;
            r_state     <= S_ERR;
          end else if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_sel   <= 2'b00;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_idx != LAST_IDX) begin
            r_idx   <= r_idx + 6'd1;
            r_tcnt  <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_sel   <= 2'b11;
            r_adr   <= tap_adr(r_idx + 6'd1);
            r_state <= S_READ;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_ERR: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_coef_tready = r_tready;
  assign wb_adr        = r_adr;
  assign wb_wr_dat     = r_wr_dat;
  assign wb_we         = r_we;
  assign wb_stb        = r_stb;
  assign wb_cyc        = r_cyc;
  assign wb_sel        = r_sel;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign err_index     = r_err_index;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader: a Wishbone slave model, a transaction-level
// expectation model (write list, read list, final outcome) and one per-cycle checker.
module tb_fir_coef_loader;

  localparam int N  = 33;
  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic        verify_en;
  logic [15:0] s_coef_tdata;
  logic        s_coef_tvalid;
  logic        s_coef_tready;
  logic [7:0]  wb_adr;
  logic [15:0] wb_wr_dat;
  logic [15:0] wb_rd_dat;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [1:0]  wb_sel;
  logic        wb_ack;
  logic        wb_err;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [5:0]  err_index;

  fir_coef_loader #(.NUM_TAPS(N), .BASE_ADR(8'h00), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .verify_en(verify_en),
    .s_coef_tdata(s_coef_tdata), .s_coef_tvalid(s_coef_tvalid), .s_coef_tready(s_coef_tready),
    .wb_adr(wb_adr), .wb_wr_dat(wb_wr_dat), .wb_rd_dat(wb_rd_dat),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual none required one (cycle %0d)", name, cyc);
  endtask

  // ---------------- Wishbone slave model ----------------
  logic [15:0] mem [256];
  int          ack_len  = 1;
  int          drop_adr = -1;
  int          err_adr  = -1;
  int          ack_left = 0;
  logic        ack_is_err = 1'b0;
  logic [7:0]  ack_adr = 8'h00;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb && wb_we && (int'(wb_adr) != drop_adr)) mem[wb_adr] = wb_wr_dat;
    if (ack_left > 0) begin
      ack_left--;
      wb_ack    = !ack_is_err;
      wb_err    = ack_is_err;
      wb_rd_dat = mem[ack_adr];
    end else begin
      wb_ack    = 1'b0;
      wb_err    = 1'b0;
      wb_rd_dat = 16'h0000;
      if (wb_cyc && wb_stb && !wb_we && ack_len > 0) begin
        ack_left   = ack_len;
        ack_adr    = wb_adr;
        ack_is_err = (int'(wb_adr) == err_adr);
      end
    end
  end

  // ---------------- expectation model ----------------
  logic [15:0] words [64];
  logic [23:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        exp_err;
  logic [1:0]  exp_code;
  logic [5:0]  exp_idx;
  int          exp_rd_len;
  logic        active = 1'b0;
  logic        last_err = 1'b0;
  logic [1:0]  last_code = 2'b00;
  logic [5:0]  last_idx = 6'd0;
  int          st_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          rd_in_load = 0;
  int          last_rd_len = 0;

  task automatic plan(input bit v);
    logic [15:0] stored;
    exp_wr.delete();
    exp_rd.delete();
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_idx  = 6'd0;
    for (int i = 0; i < N; i++) exp_wr.push_back({8'(i), words[i]});
    if (v) begin
      for (int i = 0; i < N; i++) begin
        stored = (i == drop_adr) ? mem[i] : words[i];
        exp_rd.push_back(8'(i));
        if (ack_len == 0) begin exp_err = 1; exp_code = 2'b11; exp_idx = 6'(i); break; end
        if (i == err_adr) begin exp_err = 1; exp_code = 2'b10; exp_idx = 6'(i); break; end
        if (stored != words[i]) begin exp_err = 1; exp_code = 2'b01; exp_idx = 6'(i); break; end
      end
    end
    exp_rd_len = (ack_len == 0) ? TO : 2;
    wr_cnt     = 0;
    rd_in_load = 0;
  endtask

  // ---------------- per-cycle checker ----------------
  logic prev_rst = 1'b0, prev_done = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
  int   rd_len = 0, gap_len = 0;
  logic [7:0]  cur_rd_adr = 8'h00;
  logic [23:0] wr_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else if (prev_rst) begin
      chk("rst_wb_outputs", 32'({wb_adr, wb_wr_dat, wb_we, wb_stb, wb_cyc, wb_sel}), 32'd0);
      chk("rst_ctl_outputs", 32'({s_coef_tready, busy, done, error, err_code, err_index}), 32'd0);
      prev_done = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0; rd_len = 0; gap_len = 0;
    end else begin
      chk("wb_sel", 32'(wb_sel), wb_cyc ? 32'd3 : 32'd0);
      chk("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
      chk("tready_vs_cyc", 32'(s_coef_tready & wb_cyc), 32'd0);
      if (!active) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_error", 32'({error, err_code, err_index}), 32'({last_err, last_code, last_idx}));
      end else if (s_coef_tready || wb_cyc) begin
        chk("busy_active", 32'(busy), 32'd1);
      end
      if (wb_stb && wb_we) begin
        wr_cnt++;
        chk("write_one_cycle", 32'(prev_wr), 32'd0);
        chk("write_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          wr_e = exp_wr.pop_front();
          chk("write_adr", 32'(wb_adr), 32'(wr_e[23:16]));
          chk("write_dat", 32'(wb_wr_dat), 32'(wr_e[15:0]));
        end
      end
      if (wb_stb && !wb_we) begin
        if (!prev_rd) begin
          chk("read_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) chk("read_adr", 32'(wb_adr), 32'(exp_rd.pop_front()));
          if (rd_in_load > 0) chk("read_gap", 32'(gap_len), 32'd1);
          rd_in_load++;
          rd_len     = 0;
          cur_rd_adr = wb_adr;
        end else begin
          chk("read_adr_hold", 32'(wb_adr), 32'(cur_rd_adr));
        end
        rd_len++;
      end else if (prev_rd) begin
        chk("read_len", 32'(rd_len), 32'(exp_rd_len));
        last_rd_len = rd_len;
        gap_len     = 1;
      end else begin
        gap_len++;
      end
      if (done) begin
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        chk("done_while_active", 32'(active), 32'd1);
        chk("done_writes_left", 32'(exp_wr.size()), 32'd0);
        chk("done_reads_left", 32'(exp_rd.size()), 32'd0);
        chk("done_outcome", 32'({error, err_code, err_index}), 32'({exp_err, exp_code, exp_idx}));
        done_cnt++;
        done_cyc  = cyc;
        active    = 1'b0;
        last_err  = exp_err;
        last_code = exp_code;
        last_idx  = exp_idx;
      end
      prev_done = done;
      prev_wr   = wb_stb & wb_we;
      prev_rd   = wb_stb & !wb_we;
    end
    prev_rst = rst;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input bit v);
    plan(v);
    start     = 1'b1;
    verify_en = v;
    active    = 1'b1;
    last_err  = 1'b0;
    last_code = 2'b00;
    last_idx  = 6'd0;
    st_cyc    = cyc;
    tick();
    start     = 1'b0;
    verify_en = ~v;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    s_coef_tvalid = 1'b0;
    repeat (gap) tick();
    s_coef_tvalid = 1'b1;
    s_coef_tdata  = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_coef_tready) begin
        tick();
        s_coef_tvalid = 1'b0;
        return;
      end
    end
    note_fail("stream_stall");
    s_coef_tvalid = 1'b0;
    tick();
  endtask

  task automatic send_stream(input int max_gap, input int pulse_at, input int count);
    for (int i = 0; i < count; i++) begin
      if (i == pulse_at) begin
        start     = 1'b1;
        verify_en = 1'b0;
        tick();
        start     = 1'b0;
      end
      send_word(words[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_done(input string name);
    int n0;
    n0 = done_cnt;
    for (int k = 0; k < 3000 && done_cnt == n0; k++) tick();
    if (done_cnt == n0) note_fail(name);
    repeat (4) tick();
    chk(name, 32'(done_cnt - n0), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) words[i] = 16'h0100 + 16'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; verify_en = 1'b0;
    s_coef_tdata = 16'h0000; s_coef_tvalid = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_rd_dat = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h3009;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("t0_busy", 32'(busy), 32'd0);
    chk("t0_wb", 32'({wb_cyc, wb_stb, wb_we, wb_sel}), 32'd0);

    // write-only ramp, full throughput
    fill_ramp();
    start_load(1'b0);
    send_stream(0, -1, N);
    wait_done("t1_done");
    chk("t1_latency", 32'(done_cyc - st_cyc), 32'd67);
    chk("t1_writes", 32'(wr_cnt), 32'd33);
    chk("t1_error", 32'(error), 32'd0);

    // verified load, single-cycle ack
    fill_random();
    ack_len = 1;
    start_load(1'b1);
    send_stream(0, -1, N);
    wait_done("t2_done");
    chk("t2_reads", 32'(rd_in_load), 32'd33);

    // dropped write at 0x06
    for (int i = 0; i < 256; i++) mem[i] = 16'h3009;
    fill_ramp();
    drop_adr = 6;
    start_load(1'b1);
    send_stream(0, -1, N);
    wait_done("t3_done");
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_index", 32'(err_index), 32'd6);
    chk("t3_reads", 32'(rd_in_load), 32'd7);
    chk("t3_error", 32'(error), 32'd1);
    drop_adr = -1;

    // slave never acks
    fill_random();
    ack_len = 0;
    start_load(1'b1);
    send_stream(0, -1, N);
    wait_done("t4_done");
    chk("t4_code", 32'(err_code), 32'd3);
    chk("t4_index", 32'(err_index), 32'd0);
    chk("t4_stb_len", 32'(last_rd_len), 32'd15);

    // ack held two cycles
    fill_random();
    ack_len = 2;
    start_load(1'b1);
    send_stream(0, -1, N);
    wait_done("t5_done");
    chk("t5_reads", 32'(rd_in_load), 32'd33);
    chk("t5_error", 32'(error), 32'd0);

    // bus error on tap 10
    fill_random();
    ack_len = 1;
    err_adr = 10;
    start_load(1'b1);
    send_stream(0, -1, N);
    wait_done("t6_done");
    chk("t6_code", 32'(err_code), 32'd2);
    chk("t6_index", 32'(err_index), 32'd10);
    err_adr = -1;

    // random tvalid gaps, extra start while busy
    fill_random();
    start_load(1'b1);
    send_stream(3, 7, N);
    wait_done("t7_done");
    chk("t7_reads", 32'(rd_in_load), 32'd33);

    // reset after the 10th write, then full reload
    fill_random();
    n0 = done_cnt;
    start_load(1'b0);
    send_stream(2, -1, 10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    active = 1'b0;
    last_err = 1'b0; last_code = 2'b00; last_idx = 6'd0;
    chk("t9_writes", 32'(wr_cnt), 32'd10);
    exp_wr.delete();
    exp_rd.delete();
    repeat (5) tick();
    chk("t9_no_done", 32'(done_cnt - n0), 32'd0);
    fill_random();
    start_load(1'b0);
    send_stream(1, -1, N);
    wait_done("t9_reload_done");
    chk("t9_reload_writes", 32'(wr_cnt), 32'd33);

    // start coincident with reset is ignored
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("t8_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
